stream_wrr_arbiter: RTL and testbench

Weighted round-robin arbiter that shares one valid/ready output stream among N_INP packetised input streams.
- Each input receives up to its programmed weight of consecutive packets before priority rotates.
- Packets (delimited by last) are never interleaved.
- Once oup_valid_o is asserted, oup_data_o, oup_last_o and oup_idx_o stay invariant until the handshake.
- Sits in front of shared resources (memory ports, interconnect links) where plain per-beat round-robin would split bursts.

---
 rtl/stream_arb_pkg.sv | 20 ++
 rtl/stream_wrr_arbiter_rr_pick.sv | 42 ++++
 rtl/stream_wrr_arbiter.sv | 119 +++++++++++
 tb/tb_stream_wrr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared helpers for packet-stream arbiters.
// Index/credit width derivation and the 0->1 effective-weight mapping.
package stream_arb_pkg;

  localparam int unsigned MAX_W = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Credit counts packets; one turn never exceeds the weight field.
  function automatic int unsigned credit_width(input int unsigned weight_w);
    return weight_w;
  endfunction

  function automatic logic [MAX_W-1:0] eff_weight(input logic [MAX_W-1:0] w);
    return (w == '0) ? MAX_W'(1) : w;
  endfunction

endpackage

// File: rtl/stream_wrr_arbiter_rr_pick.sv
// Rotating find-first-set: first set req bit at or after ptr (cyclic).
// Ports: req_i, ptr_i in; idx_o (granted index), found_o (any req) out.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_INP = 4,
  localparam int unsigned IDX_W = idx_width(N_INP)
) (
  input  logic [N_INP-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_INP);

  logic [2*N_INP-1:0] dbl;
  logic [N_INP-1:0]   rot;
  logic [IDX_W-1:0]   ofs;
  logic [IDX_W:0]     sum;

  // Doubling the request vector turns the wrap-around search into a
  // plain shift followed by a trailing-zero count.
  always_comb begin
    dbl     = {req_i, req_i};
    rot     = N_INP'(dbl >> ptr_i);
    ofs     = '0;
    found_o = 1'b0;
    for (int i = N_INP - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ofs     = IDX_W'(i);
        found_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, ofs};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin arbiter over packetised valid/ready streams.
// Ports: weight_i, inp_* (N_INP streams in), oup_* (one stream out).
module stream_wrr_arbiter
  import stream_arb_pkg::*;
#(
  parameter type         DATA_T   = logic,
  parameter int unsigned N_INP    = 4,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned IDX_W   = idx_width(N_INP)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_INP-1:0][WEIGHT_W-1:0]   weight_i,
  input  DATA_T                            inp_data_i [N_INP],
  input  logic [N_INP-1:0]                 inp_valid_i,
  input  logic [N_INP-1:0]                 inp_last_i,
  output logic [N_INP-1:0]                 inp_ready_o,
  output DATA_T                            oup_data_o,
  output logic                             oup_valid_o,
  output logic                             oup_last_o,
  output logic [IDX_W-1:0]                 oup_idx_o,
  input  logic                             oup_ready_i
);

  localparam int unsigned    CRED_W   = credit_width(WEIGHT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INP - 1);

  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              locked_q, locked_d;
  logic [CRED_W-1:0] credit_q, credit_d;

  logic [IDX_W-1:0]  start_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  sel;
  logic              keep;
  logic              new_grant;
  logic              sel_valid;
  logic              hs;
  logic [CRED_W-1:0] fresh;
  logic [CRED_W-1:0] base;

  always_comb begin
    start_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
  end

  rr_pick #(
    .N_INP (N_INP)
  ) u_pick (
    .req_i   (inp_valid_i),
    .ptr_i   (start_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // The owner keeps the grant mid-packet, or between packets while it
  // still has credit and is offering; otherwise the turn rotates and
  // any unused credit is dropped.
  always_comb begin
    keep      = locked_q | ((credit_q != '0) & inp_valid_i[owner_q]);
    new_grant = ~keep;
    sel       = keep ? owner_q : pick_idx;
    sel_valid = keep ? inp_valid_i[owner_q] : pick_found;
    fresh     = CRED_W'(eff_weight(MAX_W'(weight_i[sel])));
    base      = new_grant ? fresh : credit_q;
  end

  always_comb begin
    oup_valid_o = sel_valid & ~rst_i;
    oup_data_o  = inp_data_i[sel];
    oup_last_o  = inp_last_i[sel];
    oup_idx_o   = rst_i ? '0 : sel;
    hs          = oup_valid_o & oup_ready_i;
    inp_ready_o = '0;
    if (hs) begin
      inp_ready_o[sel] = 1'b1;
    end
  end

  // Any offered beat locks the selection, so a stalled output cannot
  // change; only the last beat of a packet unlocks and spends credit.
  always_comb begin
    owner_d  = owner_q;
    locked_d = locked_q;
    credit_d = credit_q;
    if (oup_valid_o) begin
      owner_d  = sel;
      locked_d = 1'b1;
      credit_d = base;
      if (hs & oup_last_o) begin
        locked_d = 1'b0;
        credit_d = base - CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= LAST_IDX;
      locked_q <= 1'b0;
      credit_q <= '0;
    end else begin
      owner_q  <= owner_d;
      locked_q <= locked_d;
      credit_q <= credit_d;
    end
  end

  a_n_inp : assert property (@(posedge clk_i) N_INP >= 2);

  a_ready_onehot : assert property (
    @(posedge clk_i) $onehot0(inp_ready_o));

  a_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (oup_valid_o && !oup_ready_i) |=>
      ($stable(oup_data_o) && $stable(oup_last_o) && $stable(oup_idx_o)));

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Bench for stream_wrr_arbiter: directed grant sequences plus random
// traffic against a packet-queue reference model.
module tb_stream_wrr_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [N-1:0][3:0] weight;
  logic [7:0]      inp_data [N];
  logic [N-1:0]    inp_valid;
  logic [N-1:0]    inp_last;
  logic [N-1:0]    inp_ready;
  logic [7:0]      oup_data;
  logic            oup_valid;
  logic            oup_last;
  logic [1:0]      oup_idx;
  logic            oup_ready;

  stream_wrr_arbiter #(
    .DATA_T   (logic [7:0]),
    .N_INP    (N),
    .WEIGHT_W (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .weight_i    (weight),
    .inp_data_i  (inp_data),
    .inp_valid_i (inp_valid),
    .inp_last_i  (inp_last),
    .inp_ready_o (inp_ready),
    .oup_data_o  (oup_data),
    .oup_valid_o (oup_valid),
    .oup_last_o  (oup_last),
    .oup_idx_o   (oup_idx),
    .oup_ready_i (oup_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t q [N][$];
  int    hs_log [$];
  int    total = 0;
  int    bad = 0;
  int    seq = 0;
  int    m_owner = N - 1;
  bit    m_locked = 0;
  int    m_credit = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int i, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = 8'(seq);
      b.l = (k == len - 1);
      seq++;
      q[i].push_back(b);
    end
  endtask

  function automatic int eff_w(input int i);
    return (weight[i] == 0) ? 1 : int'(weight[i]);
  endfunction

  task automatic step(input logic rdy);
    int   s;
    bit   ng;
    bit   ev;
    beat_t hd;
    oup_ready = rdy;
    for (int i = 0; i < N; i++) begin
      inp_valid[i] = (q[i].size() != 0);
      if (q[i].size() != 0) begin
        hd = q[i][0];
        inp_data[i] = hd.d;
        inp_last[i] = hd.l;
      end else begin
        inp_data[i] = 8'h00;
        inp_last[i] = 1'b0;
      end
    end
    #2;
    s  = m_owner;
    ng = 0;
    if (!m_locked && !(m_credit > 0 && q[m_owner].size() != 0)) begin
      ng = 1;
      for (int k = N; k >= 1; k--) begin
        if (q[(m_owner + k) % N].size() != 0) s = (m_owner + k) % N;
      end
    end
    ev = (q[s].size() != 0) && !rst;
    if (rst) begin
      chk("rst_valid", 32'(oup_valid), 0);
      chk("rst_ready", 32'(inp_ready), 0);
      chk("rst_idx", 32'(oup_idx), 0);
    end else begin
      chk("valid", 32'(oup_valid), 32'(ev));
      chk("ready", 32'(inp_ready), (ev && rdy) ? (32'd1 << s) : 0);
      if (ev) begin
        hd = q[s][0];
        chk("idx", 32'(oup_idx), 32'(s));
        chk("data", 32'(oup_data), 32'(hd.d));
        chk("last", 32'(oup_last), 32'(hd.l));
      end
    end
    if (oup_valid && oup_ready) hs_log.push_back(int'(oup_idx));
    @(posedge clk);
    #1;
    if (rst) begin
      m_owner  = N - 1;
      m_locked = 0;
      m_credit = 0;
    end else if (ev) begin
      if (ng) m_credit = eff_w(s);
      m_owner  = s;
      m_locked = 1;
      if (rdy) begin
        hd = q[s].pop_front();
        if (hd.l) begin
          m_locked = 0;
          m_credit = m_credit - 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    hs_log.delete();
  endtask

  task automatic chk_seq(input string tag, input int n,
                         input logic [63:0] exp);
    int got;
    for (int k = 0; k < n; k++) begin
      got = (k < hs_log.size()) ? hs_log[k] : 15;
      chk($sformatf("%s[%0d]", tag, k), 32'(got),
          32'(exp[4*(n-1-k) +: 4]));
    end
  endtask

  task automatic drain();
    int left;
    for (int c = 0; c < 200; c++) begin
      left = 0;
      for (int i = 0; i < N; i++) left += q[i].size();
      if (left != 0) step(1'b1);
    end
    left = 0;
    for (int i = 0; i < N; i++) left += q[i].size();
    chk("drain_timeout", 32'(left), 0);
  endtask

  initial begin
    rst       = 1'b1;
    oup_ready = 1'b0;
    inp_valid = '0;
    inp_last  = '0;
    for (int i = 0; i < N; i++) begin
      inp_data[i] = 8'h00;
      weight[i]   = 4'd1;
    end
    @(posedge clk);
    #1;

    // Equal weights, two busy single-beat sources alternate.
    push_pkt(0, 1);
    push_pkt(1, 1);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (q[0].size() < 2) push_pkt(0, 1);
      if (q[1].size() < 2) push_pkt(1, 1);
      step(1'b1);
    end
    chk_seq("alt", 6, 64'h010101);

    // Weight 3 vs 1 (input 0 programmed as 3).
    weight[0] = 4'd3;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (q[0].size() < 2) push_pkt(0, 1);
      if (q[1].size() < 2) push_pkt(1, 1);
      step(1'b1);
    end
    chk_seq("w31", 8, 64'h00010001);

    // Weight 0 behaves as 1.
    weight[0] = 4'd0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (q[0].size() < 2) push_pkt(0, 1);
      if (q[1].size() < 2) push_pkt(1, 1);
      step(1'b1);
    end
    chk_seq("w0", 4, 64'h0101);
    weight[0] = 4'd1;

    // Multi-beat packet is never interleaved.
    do_reset();
    push_pkt(0, 4);
    for (int c = 0; c < 7; c++) begin
      if (q[1].size() < 2) push_pkt(1, 1);
      step(1'b1);
    end
    chk_seq("pkt", 7, 64'h0000111);
    drain();

    // Stall with inputs 2 and 3 valid.
    do_reset();
    push_pkt(2, 2);
    push_pkt(3, 1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      chk("stall_idx", 32'(oup_idx), 2);
    end
    for (int c = 0; c < 3; c++) step(1'b1);
    chk_seq("stall", 3, 64'h223);

    // Owner goes idle with credit left, then returns with fresh credit.
    weight[0] = 4'd3;
    do_reset();
    push_pkt(0, 1);
    push_pkt(2, 1);
    push_pkt(2, 1);
    for (int c = 0; c < 3; c++) step(1'b1);
    for (int c = 0; c < 3; c++) push_pkt(0, 1);
    push_pkt(2, 1);
    push_pkt(2, 1);
    for (int c = 0; c < 5; c++) step(1'b1);
    chk_seq("idle", 8, 64'h02200022);
    weight[0] = 4'd1;

    // Reset in the middle of a locked packet.
    do_reset();
    push_pkt(1, 4);
    step(1'b1);
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    hs_log.delete();
    push_pkt(1, 1);
    push_pkt(2, 1);
    push_pkt(0, 1);
    for (int c = 0; c < 3; c++) step(1'b1);
    chk_seq("midrst", 3, 64'h012);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        for (int i = 0; i < N; i++) weight[i] = 4'($urandom_range(0, 3));
      end
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 6 && $urandom_range(0, 3) == 0) begin
          push_pkt(i, $urandom_range(1, 3));
        end
      end
      step(1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
